mvu_job_dispatcher: RTL

// - Queues MVU job descriptors (mvu id, prec, baddr, iword) from the pito-side job port in a FIFO.
// - Dispatches them in order onto the per-MVU data transposer slices, one start pulse per job.
// - Tracks busy/ack per MVU, raises a sticky per-MVU completion irq and flags ack timeouts.
// - Sits between the pito CSR/job logic and the mvu_data_* bus of barvinn.

---
 rtl/mvu_job_dispatcher.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mvu_job_dispatcher.sv
// mvu_job_dispatcher
//   Queues MVU job descriptors from the pito job port and dispatches them in
//   order to the per-MVU data slices, one start pulse per job. Tracks which
//   MVUs have a job in flight, raises a sticky per-MVU completion irq and a
//   sticky error flag for ack timeouts and invalid MVU indices.
//
//   Ports
//     clk, rst             system clock, synchronous active-high reset
//     job_valid/job_ready  descriptor handshake (job_ready registered)
//     job_mvu/prec/baddr/iword  descriptor fields
//     mvu_data_prec/baddr/iword per-MVU slices (DW each), held between jobs
//     mvu_data_start       one-cycle start pulse per MVU
//     mvu_data_busy        MVU busy inputs
//     irq_done / irq_clr   sticky completion flags and their clears
//     fifo_count           descriptors currently queued
//     err_tmo              sticky error flag, cleared only by rst
//
//   Build option: define MVU_ACK_TIMEOUT_EN to abandon a job whose MVU does
//   not raise busy within ACK_TMO cycles of its start pulse. Without it the
//   dispatcher waits for busy indefinitely.
module mvu_job_dispatcher #(
    parameter int NMVU    = 8,
    parameter int DEPTH   = 4,
    parameter int DW      = 32,
    parameter int ACK_TMO = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [$clog2(NMVU)-1:0] job_mvu,
    input  logic [DW-1:0]           job_prec,
    input  logic [DW-1:0]           job_baddr,
    input  logic [DW-1:0]           job_iword,
    output logic [NMVU*DW-1:0]      mvu_data_prec,
    output logic [NMVU*DW-1:0]      mvu_data_baddr,
    output logic [NMVU*DW-1:0]      mvu_data_iword,
    output logic [NMVU-1:0]         mvu_data_start,
    input  logic [NMVU-1:0]         mvu_data_busy,
    output logic [NMVU-1:0]         irq_done,
    input  logic [NMVU-1:0]         irq_clr,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    err_tmo
);

    localparam int MW = $clog2(NMVU);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Pointer wrap relies on a power-of-2 depth; the timer needs ACK_TMO >= 2.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ACK_TMO < 2) begin : g_bad_params
        $error("mvu_job_dispatcher: DEPTH must be a power of 2 >= 2 and ACK_TMO >= 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK} state_t;

    state_t          state;
    logic [MW-1:0]   mem_mvu   [DEPTH];
    logic [DW-1:0]   mem_prec  [DEPTH];
    logic [DW-1:0]   mem_baddr [DEPTH];
    logic [DW-1:0]   mem_iword [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_next;
    logic            push, pop;
    logic [MW-1:0]   head_mvu, cur_mvu;
    logic            head_ok, head_go;
    logic [NMVU-1:0] pending, busy_q, done_set;

`ifdef MVU_ACK_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TMO) + 1;
    logic [TW-1:0]   timer;
`endif

    assign push       = job_valid & job_ready;
    assign pop        = (state == S_ISSUE);
    assign head_mvu   = mem_mvu[rd_ptr];
    // Widened compare so a non-power-of-2 NMVU can flag out-of-range indices.
    assign head_ok    = ({1'b0, head_mvu} < (MW + 1)'(NMVU));
    assign head_go    = (count != '0) &&
                        (!head_ok || (!mvu_data_busy[head_mvu] && !pending[head_mvu]));
    // Completion: busy falls on an MVU that still owns a dispatched job.
    assign done_set   = busy_q & ~mvu_data_busy & pending;
    assign fifo_count = count;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (!push && pop)
            count_next = count - 1'b1;
    end

    // Descriptor storage carries no reset; only pointers and count define content.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_mvu[wr_ptr]   <= job_mvu;
            mem_prec[wr_ptr]  <= job_prec;
            mem_baddr[wr_ptr] <= job_baddr;
            mem_iword[wr_ptr] <= job_iword;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            job_ready <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            job_ready <= (count_next < CW'(DEPTH));
        end
    end

    // Dispatch FSM. Start pulse, slices and pending are loaded on the edge
    // entering ISSUE so they are all visible during the ISSUE cycle; the head
    // is popped at the end of ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cur_mvu        <= '0;
            mvu_data_start <= '0;
            mvu_data_prec  <= '0;
            mvu_data_baddr <= '0;
            mvu_data_iword <= '0;
            pending        <= '0;
            busy_q         <= '0;
            irq_done       <= '0;
            err_tmo        <= 1'b0;
`ifdef MVU_ACK_TIMEOUT_EN
            timer          <= '0;
`endif
        end else begin
            busy_q         <= mvu_data_busy;
            mvu_data_start <= '0;
            // A new completion overrides a simultaneous clear.
            irq_done       <= (irq_done & ~irq_clr) | done_set;
            pending        <= pending & ~done_set;
            case (state)
                S_IDLE: begin
                    if (head_go) begin
                        state   <= S_ISSUE;
                        cur_mvu <= head_mvu;
`ifdef MVU_ACK_TIMEOUT_EN
                        timer   <= '0;
`endif
                        if (head_ok) begin
                            mvu_data_start[head_mvu]          <= 1'b1;
                            mvu_data_prec[head_mvu*DW +: DW]  <= mem_prec[rd_ptr];
                            mvu_data_baddr[head_mvu*DW +: DW] <= mem_baddr[rd_ptr];
                            mvu_data_iword[head_mvu*DW +: DW] <= mem_iword[rd_ptr];
                            pending[head_mvu]                 <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
`ifdef MVU_ACK_TIMEOUT_EN
                    // The timer counts from the ISSUE cycle itself.
                    timer <= timer + 1'b1;
`endif
                    if (head_ok) begin
                        state <= S_WAIT_ACK;
                    end else begin
                        // Invalid target: job dropped without a start pulse.
                        err_tmo <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_WAIT_ACK: begin
                    if (mvu_data_busy[cur_mvu]) begin
                        state <= S_IDLE;
`ifdef MVU_ACK_TIMEOUT_EN
                    end else if (timer == TW'(ACK_TMO - 1)) begin
                        err_tmo          <= 1'b1;
                        pending[cur_mvu] <= 1'b0;
                        state            <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
